layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Host-side initiator for the accelerator control memory. It copies per-layer descriptors into the control BRAM, arms the accelerator by writing the CTRL word with start set, and polls CTRL until the accelerator writes back done.
- Sits on control BRAM port B. The accelerator top uses port A.
- Steps through i_num_layers layers back to back, then reports completion, a timeout, or an abort.

Parameters:
- DESC_AW, 10, descriptor memory word-address width.
- POLL_GAP, 8, idle cycles between CTRL polls; minimum 1.
- TIMEOUT, 2^24-1, per-layer cycle limit counted from arm; 0 disables the limit.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_run  in  1  start pulse; sampled only in IDLE.
- i_abort  in  1  abort; highest priority in every non-IDLE state.
- i_num_layers  in  4  number of layers to run; 0 completes immediately.
- i_desc_base  in  DESC_AW  word address of the layer-0 descriptor.
- o_desc_addr  out  DESC_AW  descriptor memory address; read latency 1.
- i_desc_data  in  32  descriptor read data.
- o_ctrl_addr  out  6  control BRAM byte address (word*4); read latency 1.
- o_ctrl_we  out  1  control BRAM write enable.
- o_ctrl_data  out  32  control BRAM write data.
- i_ctrl_data  in  32  control BRAM read data.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last layer completes.
- o_error  out  1  timeout flag; sticky until the next i_run or i_abort.
- o_layer  out  4  index of the current layer.

Behaviour:
- Control memory map (word: fields):
  - 0 CTRL: [8:5] cur_layer, [4] maxpool, [3] bn/relu, [2] conv, [1] done, [0] start.
  - 2 PARAM1: [7:0] width, [15:8] height, [17:16] kernel size, [18] pad, [20:19] stride.
  - 3 PARAM2: [9:0] ci, [19:10] co.
  - 4..12: kernel weights w0..w8, each in [15:0].
  - 13..15: reserved; never written.
- Descriptor layout: 12 words per layer at i_desc_base + layer*12 + k.
  - k=0 goes to word 2; k=1 to word 3; k=2..10 to words 4..12; k=11 is the CTRL template.
- Reset: every output is 0; state IDLE; layer, k and all counters are 0.
- States: IDLE, LOAD, POLL_RD, POLL_CHK, GAP, NEXT, ABORT, ERR.
- IDLE:
  - i_run=1 with i_num_layers=0: o_done pulses the next cycle and the state stays IDLE.
  - i_run=1 otherwise: clear o_error, set layer=0 and k=0, go to LOAD.
- LOAD runs 13 cycles, k=0..12:
  - For k<12, o_desc_addr = base + layer*12 + k.
  - For k>=1, write i_desc_data to the mapped word for k-1.
  - At k=12, write word 0 as {template[31:9], layer[3:0], template[4:2], done=0, start=1}. CTRL is therefore always written last.
  - Then clear the timeout counter and go to POLL_RD.
- POLL_RD: o_ctrl_addr=0, we=0; go to POLL_CHK.
- POLL_CHK: sample i_ctrl_data.
  - If bit1=1 and bit0=0, go to NEXT.
  - Otherwise go to GAP.
- GAP: wait POLL_GAP cycles, then go to POLL_RD.
- Timeout: the counter runs in POLL_RD, POLL_CHK and GAP. When it reaches TIMEOUT (TIMEOUT≠0), go to ERR.
- ERR: o_error=1, o_busy=1, no memory traffic. Leave on i_abort, or on i_run, which restarts at layer 0.
- NEXT:
  - If layer+1 == i_num_layers: pulse o_done and go to IDLE.
  - Otherwise: layer++, k=0, go to LOAD.
- o_layer holds its last value in IDLE.
- ABORT (entered on i_abort from any non-IDLE state):
  - One cycle writing word 0 = 0.
  - Then IDLE, with no o_done and o_error cleared.
  - If abort and done are seen in the same cycle, abort wins.
- i_run while busy is ignored, except in ERR.
- The sequencer never writes word 0 while a layer is in flight; the accelerator alone writes it between arm and done.
- Address arithmetic is modulo 2^DESC_AW; wrap is not flagged.
- Any control BRAM output not driven by the current state is 0.

Decomposition:
- Package ctrl_map_pkg holds:
  - word-index constants: CTRL=0, PARAM1=2, PARAM2=3, KERN0=4, KERN_N=9;
  - CTRL bit positions: START=0, DONE=1, CONV=2, BNRELU=3, MAXPOOL=4, LAYER_LSB=5;
  - DESC_WORDS=12;
  - a function mapping k to a control word index;
  - the state encoding.
- No sub-module. A single FSM plus counters is enough.

Test Plan:
- Reset held low mid-LOAD, then released: all outputs 0, state IDLE, no write occurs on the release cycle.
- num_layers=1, template 0x04, accelerator model sets done after 100 cycles:
  - 12 writes in order, to byte addresses 8, 12, 16..48, then 0;
  - the last write data is 0x00000005;
  - o_done pulses once, about 100+POLL_GAP cycles after arm.
- num_layers=3, templates alternate conv/maxpool:
  - the cur_layer field written is 0, 1, 2;
  - descriptor addresses are base+0..11, base+12..23, base+24..35;
  - o_layer sequence is 0, 1, 2, and exactly one o_done.
- TIMEOUT=50, accelerator never responds:
  - o_error rises 50 cycles after arm and o_busy stays 1;
  - a following i_run clears o_error and restarts at layer 0.
- i_abort asserted in GAP of layer 1: the next cycle writes addr 0 with data 0, then IDLE; o_done never pulses.
- i_run held high through an entire run: exactly one run executes; after the first done a new run starts only from IDLE.

Source files
------------

// File: rtl/ctrl_map_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_map_pkg
// Purpose : Shared view of the accelerator control BRAM: word indices, CTRL
//           bit positions, descriptor geometry, the descriptor-slot to
//           control-word mapping and the layer_sequencer state encoding.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package ctrl_map_pkg;

   // Control BRAM word indices
   localparam int unsigned CTRL   = 0;
   localparam int unsigned PARAM1 = 2;
   localparam int unsigned PARAM2 = 3;
   localparam int unsigned KERN0  = 4;
   localparam int unsigned KERN_N = 9;

   // CTRL word bit positions
   localparam int unsigned START     = 0;
   localparam int unsigned DONE      = 1;
   localparam int unsigned CONV      = 2;
   localparam int unsigned BNRELU    = 3;
   localparam int unsigned MAXPOOL   = 4;
   localparam int unsigned LAYER_LSB = 5;

   // Descriptor words per layer; the last one is the CTRL template
   localparam int unsigned DESC_WORDS = 12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_POLL_RD,
      S_POLL_CHK,
      S_GAP,
      S_NEXT,
      S_ABORT,
      S_ERR
   } seq_state_e;

   // Descriptor slot k -> control word index.
   // 0 -> PARAM1, 1 -> PARAM2, 2..10 -> KERN0..KERN0+KERN_N-1, 11 -> CTRL.
   function automatic logic [3:0] desc_word(input logic [3:0] k);
      logic [3:0] w;
      case (k)
         4'd0:                     w = 4'(PARAM1);
         4'd1:                     w = 4'(PARAM2);
         4'(DESC_WORDS - 1):       w = 4'(CTRL);
         default:                  w = 4'(KERN0) + (k - 4'd2);
      endcase
      return w;
   endfunction

endpackage

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Purpose : Host-side initiator on control BRAM port B. For each layer it
//           copies the 12-word descriptor into the control BRAM (CTRL last,
//           with start set), then polls CTRL until the accelerator reports
//           done. Runs i_num_layers layers back to back and reports done,
//           timeout (o_error) or abort.
// Ports   : i_clk, i_rst (async, active low)
//           i_run, i_abort, i_num_layers, i_desc_base   - host control
//           o_desc_addr / i_desc_data                    - descriptor memory (1-cycle read)
//           o_ctrl_addr (byte), o_ctrl_we, o_ctrl_data,
//           i_ctrl_data                                  - control BRAM port B (1-cycle read)
//           o_busy, o_done, o_error, o_layer             - status
// ---------------------------------------------------------------------------
module layer_sequencer
   import ctrl_map_pkg::*;
#(
   parameter int unsigned DESC_AW  = 10,
   parameter int unsigned POLL_GAP = 8,
   parameter int unsigned TIMEOUT  = 32'h00FF_FFFF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_run,
   input  logic               i_abort,
   input  logic [3:0]         i_num_layers,
   input  logic [DESC_AW-1:0] i_desc_base,
   output logic [DESC_AW-1:0] o_desc_addr,
   input  logic [31:0]        i_desc_data,
   output logic [5:0]         o_ctrl_addr,
   output logic               o_ctrl_we,
   output logic [31:0]        o_ctrl_data,
   input  logic [31:0]        i_ctrl_data,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error,
   output logic [3:0]         o_layer
);

   localparam int unsigned TW = (TIMEOUT < 2)  ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   seq_state_e    state_q, state_d;
   logic [3:0]    layer_q, layer_d;
   logic [3:0]    k_q, k_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [3:0]         ctrl_word;
   logic [DESC_AW-1:0] desc_addr;
   logic               polling;
   logic               unused_ctrl;

   // Wraps modulo 2^DESC_AW by truncation.
   assign desc_addr = DESC_AW'(32'(i_desc_base) + 32'(layer_q) * 32'd12 + 32'(k_q));
   assign polling   = (state_q == S_POLL_RD) || (state_q == S_POLL_CHK) || (state_q == S_GAP);
   assign unused_ctrl = ^i_ctrl_data[31:2];

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         layer_q <= '0;
         k_q     <= '0;
         gap_q   <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         k_q     <= k_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      layer_d     = layer_q;
      k_d         = k_q;
      gap_d       = gap_q;
      tmo_d       = tmo_q;
      done_d      = 1'b0;
      err_d       = err_q;
      o_desc_addr = '0;
      ctrl_word   = '0;
      o_ctrl_we   = 1'b0;
      o_ctrl_data = '0;

      case (state_q)
         S_IDLE: begin
            if (i_run) begin
               err_d = 1'b0;
               if (i_num_layers == 4'd0) begin
                  done_d = 1'b1;
               end else begin
                  layer_d = '0;
                  k_d     = '0;
                  state_d = S_LOAD;
               end
            end
         end
         // Cycle k issues descriptor read k and writes the word read at k-1,
         // so the CTRL template (slot 11) lands in the final cycle k=12.
         S_LOAD: begin
            if (k_q < 4'(DESC_WORDS))
               o_desc_addr = desc_addr;
            if (k_q != 4'd0) begin
               o_ctrl_we = 1'b1;
               ctrl_word = desc_word(k_q - 4'd1);
               if (k_q == 4'(DESC_WORDS))
                  // Arm: keep template fields, insert layer, force done=0 start=1
                  o_ctrl_data = {i_desc_data[31:9], layer_q, i_desc_data[4:2], 1'b0, 1'b1};
               else
                  o_ctrl_data = i_desc_data;
            end
            if (k_q == 4'(DESC_WORDS)) begin
               tmo_d   = '0;
               state_d = S_POLL_RD;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_POLL_RD: state_d = S_POLL_CHK;
         S_POLL_CHK: begin
            if (i_ctrl_data[DONE] && !i_ctrl_data[START]) begin
               state_d = S_NEXT;
            end else begin
               gap_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = S_POLL_RD;
            else                   gap_d   = gap_q + GW'(1);
         end
         S_NEXT: begin
            if ({1'b0, layer_q} + 5'd1 == {1'b0, i_num_layers}) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               layer_d = layer_q + 4'd1;
               k_d     = '0;
               state_d = S_LOAD;
            end
         end
         S_ABORT: begin
            // Disarm: word 0 <- 0 (address/data defaults are already 0)
            o_ctrl_we = 1'b1;
            state_d   = S_IDLE;
         end
         S_ERR: begin
            if (i_run) begin
               err_d = 1'b0;
               if (i_num_layers == 4'd0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  layer_d = '0;
                  k_d     = '0;
                  state_d = S_LOAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timeout spans the whole poll loop and overrides the poll decision.
      if (polling && (TIMEOUT != 0)) begin
         tmo_d = tmo_q + TW'(1);
         if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_ERR;
         end
      end

      // Abort beats everything, including a done seen in the same cycle.
      if (i_abort && (state_q != S_IDLE)) begin
         done_d  = 1'b0;
         err_d   = 1'b0;
         state_d = S_ABORT;
      end
   end

   assign o_ctrl_addr = {ctrl_word, 2'b00};
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = done_q;
   assign o_error     = err_q;
   assign o_layer     = layer_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
   localparam int TMO_B = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        run_a = 1'b0, abort_a = 1'b0, run_b = 1'b0, abort_b = 1'b0;
   logic [3:0]  num = 4'd0;
   logic [9:0]  base = 10'd0;

   logic [9:0]  daddr_a, daddr_b;
   logic [31:0] ddata_a, ddata_b;
   logic [5:0]  caddr_a, caddr_b;
   logic        cwe_a, cwe_b;
   logic [31:0] cwdata_a, cwdata_b, crdata_a;
   logic [31:0] crdata_b;
   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [3:0]  layer_a, layer_b;

   assign crdata_b = 32'd0;   // accelerator on B never answers

   layer_sequencer #(.DESC_AW(10), .POLL_GAP(8), .TIMEOUT(32'h00FF_FFFF)) dut_a (
      .i_clk(clk), .i_rst(rst_n), .i_run(run_a), .i_abort(abort_a),
      .i_num_layers(num), .i_desc_base(base),
      .o_desc_addr(daddr_a), .i_desc_data(ddata_a),
      .o_ctrl_addr(caddr_a), .o_ctrl_we(cwe_a), .o_ctrl_data(cwdata_a), .i_ctrl_data(crdata_a),
      .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_layer(layer_a));

   layer_sequencer #(.DESC_AW(10), .POLL_GAP(8), .TIMEOUT(TMO_B)) dut_b (
      .i_clk(clk), .i_rst(rst_n), .i_run(run_b), .i_abort(abort_b),
      .i_num_layers(num), .i_desc_base(base),
      .o_desc_addr(daddr_b), .i_desc_data(ddata_b),
      .o_ctrl_addr(caddr_b), .o_ctrl_we(cwe_b), .o_ctrl_data(cwdata_b), .i_ctrl_data(crdata_b),
      .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_layer(layer_b));

   // Descriptor memory: word a holds D000_0000|a unless overwritten by a test.
   logic [31:0] desc_mem [1024];
   always @(posedge clk) begin
      ddata_a <= desc_mem[daddr_a];
      ddata_b <= desc_mem[daddr_b];
   end

   // Control BRAM + accelerator model for A: sets done acc_delay cycles after arm.
   logic [31:0] cmem [16] = '{default: 32'd0};
   int acc_cnt = 0;
   int acc_delay = 100;
   always @(posedge clk) begin
      crdata_a <= cmem[caddr_a[5:2]];
      if (cwe_a) begin
         cmem[caddr_a[5:2]] <= cwdata_a;
         if (caddr_a == 6'd0 && cwdata_a[0]) acc_cnt <= acc_delay;
      end else if (acc_cnt == 1) begin
         cmem[0] <= {cmem[0][31:2], 2'b10};
         acc_cnt <= 0;
      end else if (acc_cnt > 1) begin
         acc_cnt <= acc_cnt - 1;
      end
   end

   // Monitor of A's writes, arms and done pulses
   logic [37:0] wlog[$];
   logic [3:0]  arm_layer[$];
   int done_cnt = 0, cyc = 0, arm_cyc = 0, done_cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && cwe_a) begin
         wlog.push_back({caddr_a, cwdata_a});
         if (caddr_a == 6'd0 && cwdata_a[0]) begin
            arm_cyc <= cyc;
            arm_layer.push_back(layer_a);
         end
      end
      if (rst_n && done_a) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   int checks = 0, errors = 0;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [62:0] outs;
      repeat (2) tick();
      outs = {busy_a, done_a, err_a, cwe_a, layer_a, caddr_a, cwdata_a, daddr_a, busy_b, err_b};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_initial: got %h want 0", outs); end
      rst_n = 1'b1;
      base = 10'h010; num = 4'd1; run_a = 1'b1;
      tick(); run_a = 1'b0;
      tick(); tick();
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_preload_busy: got %b want 1", busy_a); end
      rst_n = 1'b0;
      #1;
      outs = {busy_a, done_a, err_a, cwe_a, layer_a, caddr_a, cwdata_a, daddr_a, busy_b, err_b};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_midload: got %h want 0", outs); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({cwe_a, busy_a, done_a} !== 3'b000) begin
         errors++; $display("FAIL reset_release: we/busy/done got %b want 000", {cwe_a, busy_a, done_a});
      end
   endtask

   task automatic test_zero_layers();
      num = 4'd0; run_a = 1'b1;
      tick(); run_a = 1'b0;
      checks++;
      if ({done_a, busy_a} !== 2'b10) begin errors++; $display("FAIL zero_done: done/busy got %b want 10", {done_a, busy_a}); end
      tick();
      checks++;
      if (done_a !== 1'b0) begin errors++; $display("FAIL zero_pulse: done got %b want 0", done_a); end
   endtask

   task automatic test_single();
      int d0; bit seen; logic [37:0] e; logic [31:0] exp_d; int lat;
      wlog.delete(); arm_layer.delete(); d0 = done_cnt; seen = 0;
      desc_mem[10'h01B] = 32'h0000_0004;
      acc_delay = 100; base = 10'h010; num = 4'd1; run_a = 1'b1;
      tick(); run_a = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin tick(); if (done_a) seen = 1; end
      checks++;
      if (!seen) begin errors++; $display("FAIL single_wait: done got 0 want 1 within 1000 cycles"); end
      tick();
      checks++;
      if (wlog.size() != 12) begin errors++; $display("FAIL single_nwrites: got %0d want 12", wlog.size()); end
      else begin
         for (int j = 0; j < 11; j++) begin
            e = wlog[j];
            exp_d = 32'hD000_0000 | 32'(10'h010 + 10'(j));
            checks++;
            if (e !== {6'((j + 2) * 4), exp_d}) begin
               errors++; $display("FAIL single_write%0d: got %h want %h", j, e, {6'((j + 2) * 4), exp_d});
            end
         end
         e = wlog[11];
         checks++;
         if (e !== {6'd0, 32'h0000_0005}) begin errors++; $display("FAIL single_arm: got %h want %h", e, {6'd0, 32'h5}); end
      end
      lat = done_cyc - arm_cyc;
      checks++;
      if (lat < 100 || lat > 100 + 8 + 6) begin errors++; $display("FAIL single_latency: got %0d want 100..114", lat); end
      repeat (20) tick();
      checks++;
      if (done_cnt - d0 != 1 || busy_a !== 1'b0) begin
         errors++; $display("FAIL single_once: dones %0d busy %b want 1 0", done_cnt - d0, busy_a);
      end
   endtask

   task automatic test_multi();
      int d0; bit seen; logic [37:0] e; logic [37:0] exp_e; logic [31:0] exp_ctrl [3];
      exp_ctrl[0] = 32'h0000_0005; exp_ctrl[1] = 32'h0000_0031; exp_ctrl[2] = 32'hFFFF_FE45;
      wlog.delete(); arm_layer.delete(); d0 = done_cnt; seen = 0;
      // base near the top of the space: layer 1 and 2 descriptors wrap to 0
      desc_mem[10'h3FB] = 32'h0000_0004;
      desc_mem[10'h007] = 32'h0000_0010;
      desc_mem[10'h013] = 32'hFFFF_FFE6;
      acc_delay = 30; base = 10'h3F0; num = 4'd3; run_a = 1'b1;
      tick(); run_a = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin tick(); if (done_a) seen = 1; end
      checks++;
      if (!seen) begin errors++; $display("FAIL multi_wait: done got 0 want 1 within 3000 cycles"); end
      tick();
      checks++;
      if (wlog.size() != 36) begin errors++; $display("FAIL multi_nwrites: got %0d want 36", wlog.size()); end
      else begin
         for (int l = 0; l < 3; l++) begin
            for (int j = 0; j < 12; j++) begin
               e = wlog[l * 12 + j];
               if (j == 11) exp_e = {6'd0, exp_ctrl[l]};
               else exp_e = {6'((j + 2) * 4), 32'hD000_0000 | 32'(10'(10'h3F0 + l * 12 + j))};
               checks++;
               if (e !== exp_e) begin errors++; $display("FAIL multi_L%0d_w%0d: got %h want %h", l, j, e, exp_e); end
            end
         end
      end
      checks++;
      if (arm_layer.size() != 3) begin errors++; $display("FAIL multi_narms: got %0d want 3", arm_layer.size()); end
      else begin
         for (int l = 0; l < 3; l++) begin
            checks++;
            if (arm_layer[l] !== 4'(l)) begin errors++; $display("FAIL multi_olayer%0d: got %0d want %0d", l, arm_layer[l], l); end
         end
      end
      repeat (10) tick();
      checks++;
      if (done_cnt - d0 != 1 || layer_a !== 4'd2) begin
         errors++; $display("FAIL multi_done: dones %0d o_layer %0d want 1 2", done_cnt - d0, layer_a);
      end
   endtask

   task automatic test_timeout();
      bit armed; int n;
      armed = 0; n = 0;
      base = 10'h010; num = 4'd1; run_b = 1'b1;
      tick(); run_b = 1'b0;
      for (int i = 0; i < 100 && !armed; i++) begin
         if (cwe_b && caddr_b == 6'd0 && cwdata_b[0]) armed = 1; else tick();
      end
      checks++;
      if (!armed) begin errors++; $display("FAIL tmo_arm: arm got 0 want 1 within 100 cycles"); end
      // Arm commits at the edge ending this cycle; the flag rises 50 edges
      // later, so it is first seen at the 51st falling edge from here.
      while (n < 200 && err_b !== 1'b1) begin tick(); n++; end
      checks++;
      if (n != TMO_B + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO_B + 1); end
      repeat (5) tick();
      checks++;
      if ({err_b, busy_b, cwe_b} !== 3'b110) begin
         errors++; $display("FAIL tmo_sticky: err/busy/we got %b want 110", {err_b, busy_b, cwe_b});
      end
      run_b = 1'b1;
      tick(); run_b = 1'b0;
      checks++;
      if ({err_b, busy_b, layer_b, daddr_b} !== {1'b0, 1'b1, 4'd0, 10'h010}) begin
         errors++; $display("FAIL tmo_restart: err %b busy %b layer %0d daddr %h want 0 1 0 010", err_b, busy_b, layer_b, daddr_b);
      end
      abort_b = 1'b1;
      tick(); abort_b = 1'b0;
      tick();
      checks++;
      if ({busy_b, err_b} !== 2'b00) begin errors++; $display("FAIL tmo_cleanup: busy/err got %b want 00", {busy_b, err_b}); end
   endtask

   task automatic test_abort();
      int d0; bit hit;
      d0 = done_cnt; hit = 0;
      acc_delay = 30; base = 10'h080; num = 4'd2; run_a = 1'b1;
      tick(); run_a = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         tick();
         if (cwe_a && caddr_a == 6'd0 && cwdata_a[0] && layer_a == 4'd1) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL abort_arm1: arm got 0 want 1 within 2000 cycles"); end
      repeat (3) tick();   // POLL_RD, POLL_CHK, now first GAP cycle
      abort_a = 1'b1;
      tick(); abort_a = 1'b0;
      checks++;
      if ({cwe_a, caddr_a, cwdata_a} !== {1'b1, 6'd0, 32'd0}) begin
         errors++; $display("FAIL abort_write: we %b addr %0d data %h want 1 0 0", cwe_a, caddr_a, cwdata_a);
      end
      tick();
      checks++;
      if ({busy_a, err_a} !== 2'b00) begin errors++; $display("FAIL abort_idle: busy/err got %b want 00", {busy_a, err_a}); end
      repeat (60) tick();
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL abort_nodone: dones got %0d want 0", done_cnt - d0); end
   endtask

   task automatic test_back_to_back();
      int d0; bit seen;
      wlog.delete(); arm_layer.delete(); d0 = done_cnt; seen = 0;
      acc_delay = 20; base = 10'h040; num = 4'd2; run_a = 1'b1;   // held high
      for (int i = 0; i < 3000 && !seen; i++) begin tick(); if (done_a) seen = 1; end
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b_wait: done got 0 want 1 within 3000 cycles"); end
      checks++;
      if (arm_layer.size() != 2) begin errors++; $display("FAIL b2b_narms: got %0d want 2", arm_layer.size()); end
      else begin
         checks++;
         if ({arm_layer[0], arm_layer[1]} !== 8'h01) begin
            errors++; $display("FAIL b2b_layers: got %0d,%0d want 0,1", arm_layer[0], arm_layer[1]);
         end
      end
      tick(); run_a = 1'b0;
      checks++;
      if ({busy_a, layer_a} !== {1'b1, 4'd0} || done_cnt - d0 != 1) begin
         errors++; $display("FAIL b2b_restart: busy %b layer %0d dones %0d want 1 0 1", busy_a, layer_a, done_cnt - d0);
      end
      abort_a = 1'b1;
      tick(); abort_a = 1'b0;
      tick();
      checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_cleanup: busy got %b want 0", busy_a); end
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) desc_mem[a] = 32'hD000_0000 | 32'(a);
      test_reset();
      test_zero_layers();
      test_single();
      test_multi();
      test_timeout();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
